// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and opcode constants for the fetch_q front end.
//   fetch_entry_t : one FIFO slot {addr, instr, pred_taken}
//   fetch_state_t : bus-side state (FETCH, DRAIN)
//   OPC_JAL / OPC_BRANCH : RV32 major opcodes recognised by the static predictor
package fetch_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        pred_taken;
   } fetch_entry_t;

   typedef enum logic {FETCH, DRAIN} fetch_state_t;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/static_bp.sv
// static_bp -- combinational static branch predictor.
//   instr      in  fetched instruction word
//   instr_addr in  address of that word
//   next_addr  out predicted next fetch address
//   taken      out 1 when the word redirects the fetch stream
// JAL is always taken; conditional branches are taken only when their
// offset is negative (backward, loop-closing); everything else falls through.
module static_bp
   import fetch_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] instr_addr,
   output logic [31:0] next_addr,
   output logic        taken
);

   logic [31:0] j_imm;
   logic [31:0] b_imm;
   logic        is_jal;
   logic        is_br;

   assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign is_jal = (instr[6:0] == OPC_JAL);
   assign is_br  = (instr[6:0] == OPC_BRANCH);

   // Sign bit of the B-immediate is instr[31]: set means backward branch.
   assign taken     = is_jal || (is_br && instr[31]);
   assign next_addr = is_jal ? instr_addr + j_imm :
                      taken  ? instr_addr + b_imm :
                               instr_addr + 32'd4;

endmodule

// File: rtl/fetch_q.sv
// fetch_q -- instruction-fetch front end with a DEPTH-entry FIFO.
//   clk, rst_n          clock, asynchronous active-low reset
//   ib_addr/ib_valid    fetch request (address held while stalled)
//   ib_din/ib_ready     single-beat bus response, data valid on accept
//   instr/instr_addr    head-of-FIFO entry towards decode
//   pred_taken          head entry was predicted taken
//   valid/ready         decode handshake, pop on valid && ready
//   jmp/jmp_addr        one-cycle redirect pulse and target
//   level               current FIFO occupancy
// Build option: define FETCH_BP_EN to instantiate static_bp; otherwise the
// fetch stream is strictly sequential and pred_taken is always 0.
module fetch_q
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [31:0]              ib_addr,
   output logic                     ib_valid,
   input  logic [31:0]              ib_din,
   input  logic                     ib_ready,
   output logic [31:0]              instr,
   output logic [31:0]              instr_addr,
   output logic                     pred_taken,
   output logic                     valid,
   input  logic                     ready,
   input  logic                     jmp,
   input  logic [31:0]              jmp_addr,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   tgt_q, tgt_d;
   logic [31:0]   next_pc;
   logic          bp_taken;
   logic [PW-1:0] rd_q, wr_q;
   logic [LW-1:0] level_q;
   logic          run_q;
   logic          push, pop, flush;
   fetch_entry_t  mem [DEPTH];

   // run_q keeps ib_valid low while in reset and raises it one edge after
   // release, so the request is decoded purely from registers.
   assign ib_valid   = run_q && ((state_q == DRAIN) || (level_q < LW'(DEPTH)));
   assign ib_addr    = pc_q;
   assign valid      = (level_q != '0);
   assign level      = level_q;
   assign instr      = mem[rd_q].instr;
   assign instr_addr = mem[rd_q].addr;

`ifdef FETCH_BP_EN
   static_bp u_bp (
      .instr      (ib_din),
      .instr_addr (pc_q),
      .next_addr  (next_pc),
      .taken      (bp_taken)
   );
   assign pred_taken = mem[rd_q].pred_taken;
`else
   assign next_pc    = pc_q + 32'd4;
   assign bp_taken   = 1'b0;
   assign pred_taken = 1'b0;
`endif

   // Next-state / control. A redirect wins over push and pop; if the bus is
   // mid-request we must keep the address stable, so park the target and
   // swallow the outstanding beat in DRAIN.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      flush   = 1'b0;
      push    = 1'b0;
      pop     = valid && ready;
      if (jmp) begin
         flush = 1'b1;
         pop   = 1'b0;
         tgt_d = jmp_addr;
         if (state_q == FETCH) begin
            if (ib_valid && !ib_ready) state_d = DRAIN;
            else                       pc_d    = jmp_addr;
         end
      end else if (state_q == DRAIN) begin
         if (ib_ready) begin
            pc_d    = tgt_q;
            state_d = FETCH;
         end
      end else if (ib_valid && ib_ready) begin
         push = 1'b1;
         pc_d = next_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
         run_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         if (flush) begin
            wr_q    <= rd_q;
            level_q <= '0;
         end else begin
            if (push) begin
               mem[wr_q] <= '{addr: pc_q, instr: ib_din, pred_taken: bp_taken};
               wr_q      <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
         end
      end
   end

endmodule

// File: doc/fetch_q.md
# fetch_q

Parametrised instruction-fetch front end: issues sequential word fetches on the single-beat instruction bus, buffers returned instructions in a DEPTH-entry FIFO, and presents them to decode with a valid/ready handshake. Adds configurable depth, a stable-address bus protocol with a redirect-drain state, an occupancy output and an optional static branch predictor. Sits between instruction ROM/cache and the decode stage.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ib_addr  out  32  fetch address; held stable while ib_valid && !ib_ready.
- ib_valid  out  1  fetch request.
- ib_din  in  32  instruction word, valid in the cycle ib_valid && ib_ready.
- ib_ready  in  1  bus accepts request and returns data in the same cycle.
- instr  out  32  head-of-FIFO instruction.
- instr_addr  out  32  head-of-FIFO address.
- pred_taken  out  1  head entry was predicted taken (0 when predictor compiled out).
- valid  out  1  FIFO not empty.
- ready  in  1  decode pops head when valid && ready.
- jmp  in  1  redirect; one-cycle pulse.
- jmp_addr  in  32  redirect target, word-aligned.
- level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Reset values: pc = RESET_PC, rd/wr pointers 0, level 0, valid 0, pred_taken 0, state FETCH, ib_valid 0 while rst_n low.
- ib_valid = (state == DRAIN) || (level < DEPTH). No write bypass into a full FIFO even if a pop occurs that cycle.
- Push: ib_valid && ib_ready in FETCH without jmp → write {ib_addr, ib_din, pred} at wr pointer; pc <= next_pc (pc+4, or predictor target).
- Pop: valid && ready → rd pointer +1. Push and pop in one cycle → level unchanged. Pointers wrap modulo DEPTH.
- States: FETCH, DRAIN.
- jmp in FETCH (priority over push and pop): FIFO flushed (level 0, wr pointer = rd pointer); any beat accepted this cycle is dropped.
  - ib_valid && !ib_ready that cycle → state DRAIN, target register <= jmp_addr, ib_addr stays at old pc.
  - Otherwise → pc <= jmp_addr, stay FETCH.
- DRAIN: ib_valid held 1 at old address; beat completing (ib_ready) is discarded, pc <= target, → FETCH. jmp during DRAIN: flush again, target <= new jmp_addr, stay DRAIN.
- level arithmetic is DEPTH+1-state wide; never exceeds DEPTH, never underflows (pop gated by valid).

## Timing
- Fetch-to-decode latency 1: word accepted in cycle N is valid at cycle N+1.
- Sustained 1 instruction/cycle with ib_ready and ready held high.
- After jmp in cycle N with no pending request: ib_addr = jmp_addr in N+1, valid 0 in N+1, first redirected instruction valid in N+2 at best.
- After jmp with pending request: redirected address appears the cycle after the old beat completes.
- First request: ib_valid high in first clock edge after rst_n deasserts; asynchronous reset mid-operation drops all entries and any pending request immediately.
- All outputs registered or decoded from registers; no combinational path from ib_din or ready to outputs.

## Configuration
- FETCH_BP_EN defined: static predictor instantiated; next_pc = JAL target, or conditional-branch target when B-immediate is negative, else pc+4; pred_taken stored per entry.
- Undefined: next_pc = pc+4, pred_taken tied 0, no predictor logic.

## Structure
- Package fetch_pkg: fetch_entry_t {addr[31:0], instr[31:0], pred_taken}, fetch_state_t {FETCH, DRAIN}, OPC_JAL = 7'b1101111, OPC_BRANCH = 7'b1100011.
- One sub-module: static_bp (combinational; instr, instr_addr → next_addr, taken), instantiated only under FETCH_BP_EN.

## Test plan
- Reset, ib_ready=1, ready=1, ROM word = address → valid from cycle 2, instr_addr 0,4,8,… one per cycle, level 1.
- ready=0, DEPTH=4 → after 4 pushes level=4, ib_valid=0; ready=1 one cycle → level 3, ib_valid 1, no entry lost or duplicated.
- jmp to 0x100 with ib_valid&&ib_ready same cycle → beat dropped, level 0 next cycle, next instr_addr 0x100.
- ib_ready=0 for 3 cycles, jmp to 0x200 in first → ib_addr held at old pc until ib_ready, that beat discarded, then ib_addr 0x200; a second jmp to 0x300 during DRAIN → 0x300 fetched instead.
- FETCH_BP_EN, JAL +16 at 0x20, backward BEQ −8 at 0x40 → pc 0x30 after 0x20 with pred_taken=1; 0x38 after 0x40; forward BNE → pc+4, pred_taken=0.
- rst_n low mid-stream with level 3 and DRAIN active → valid 0, level 0, state FETCH, ib_addr RESET_PC after release.
